// File: rtl/dp_arbiter_pkg.sv
// Shared widths and FSM state encoding for the dp_arbiter datapath sequencer.
package dp_arb_pkg;
    localparam int DP_W   = 3;
    localparam int OPC_W  = 3;
    localparam int SEL2_W = 2;
    localparam int STAT_W = 8;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
endpackage

// File: rtl/dp_arbiter_if.sv
// Request, datapath and response channels between requesters, dp_arbiter and the datapath.
interface dp_arbiter_if #(
    parameter int NREQ = 4,
    parameter int DP_W = dp_arb_pkg::DP_W
);
    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0]                     req_valid;
    logic [NREQ-1:0]                     req_ready;
    logic [NREQ*DP_W-1:0]                req_a, req_b, req_c, req_d, req_e;
    logic [NREQ*dp_arb_pkg::OPC_W-1:0]   req_opcode;
    logic [NREQ-1:0]                     req_sel_1;
    logic [NREQ*dp_arb_pkg::SEL2_W-1:0]  req_sel_2;

    logic [DP_W-1:0]                     dp_a, dp_b, dp_c, dp_d, dp_e;
    logic [dp_arb_pkg::OPC_W-1:0]        dp_opcode;
    logic                                dp_sel_1;
    logic [dp_arb_pkg::SEL2_W-1:0]       dp_sel_2;
    logic [DP_W-1:0]                     dp_out;
    logic                                dp_carry_out;

    logic                                resp_valid;
    logic                                resp_ready;
    logic [IDW-1:0]                      resp_id;
    logic [DP_W-1:0]                     resp_data;
    logic                                resp_carry;

    modport slave (
        input  req_valid, req_a, req_b, req_c, req_d, req_e, req_opcode, req_sel_1, req_sel_2,
        output req_ready,
        output dp_a, dp_b, dp_c, dp_d, dp_e, dp_opcode, dp_sel_1, dp_sel_2,
        input  dp_out, dp_carry_out,
        output resp_valid, resp_id, resp_data, resp_carry,
        input  resp_ready
    );

    modport master (
        output req_valid, req_a, req_b, req_c, req_d, req_e, req_opcode, req_sel_1, req_sel_2,
        input  req_ready,
        input  dp_a, dp_b, dp_c, dp_d, dp_e, dp_opcode, dp_sel_1, dp_sel_2,
        output dp_out, dp_carry_out,
        input  resp_valid, resp_id, resp_data, resp_carry,
        output resp_ready
    );
endinterface

// File: rtl/dp_arbiter_rr_pick.sv
// Combinational round-robin find-first: first set request at or above the pointer, wrapping.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IDW-1:0]  i_ptr,
    output logic [NREQ-1:0] o_gnt,
    output logic [IDW-1:0]  o_idx,
    output logic            o_any
);
    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            int j;
            j = int'(i_ptr) + i;
            if (j >= NREQ) j = j - NREQ;
            if (!o_any && i_req[j[IDW-1:0]]) begin
                o_any               = 1'b1;
                o_gnt[j[IDW-1:0]]   = 1'b1;
                o_idx               = j[IDW-1:0];
            end
        end
    end
endmodule

// File: rtl/dp_arbiter.sv
// Round-robin sequencer sharing one combinational datapath among NREQ requesters.
// Optional per-requester grant counters are built when DP_ARB_STATS_EN is defined.
module dp_arbiter
    import dp_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int DP_W = dp_arb_pkg::DP_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    dp_arbiter_if.slave              bus
`ifdef DP_ARB_STATS_EN
    , input  logic                   stats_clr
    , output logic [NREQ*STAT_W-1:0] grant_count
`endif
);
    localparam int IDW = $clog2(NREQ);

    state_t              r_state;
    logic [IDW-1:0]      r_rr_ptr, r_cur_id, r_resp_id;
    logic [DP_W-1:0]     r_dp_a, r_dp_b, r_dp_c, r_dp_d, r_dp_e, r_resp_data;
    logic [OPC_W-1:0]    r_dp_opcode;
    logic                r_dp_sel_1, r_resp_valid, r_resp_carry;
    logic [SEL2_W-1:0]   r_dp_sel_2;

    logic [NREQ-1:0]     w_gnt;
    logic [IDW-1:0]      w_idx;
    logic                w_any, w_accept;

    rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
        .i_req (bus.req_valid),
        .i_ptr (r_rr_ptr),
        .o_gnt (w_gnt),
        .o_idx (w_idx),
        .o_any (w_any)
    );

    assign w_accept      = (r_state == IDLE) && w_any;
    // Grants only in IDLE, and never while reset is asserted.
    assign bus.req_ready = (r_state == IDLE && rst_n) ? w_gnt : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_rr_ptr     <= '0;
            r_cur_id     <= '0;
            r_dp_a       <= '0;
            r_dp_b       <= '0;
            r_dp_c       <= '0;
            r_dp_d       <= '0;
            r_dp_e       <= '0;
            r_dp_opcode  <= '0;
            r_dp_sel_1   <= 1'b0;
            r_dp_sel_2   <= '0;
            r_resp_valid <= 1'b0;
            r_resp_id    <= '0;
            r_resp_data  <= '0;
            r_resp_carry <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (w_accept) begin
                    r_dp_a      <= bus.req_a[w_idx*DP_W +: DP_W];
                    r_dp_b      <= bus.req_b[w_idx*DP_W +: DP_W];
                    r_dp_c      <= bus.req_c[w_idx*DP_W +: DP_W];
                    r_dp_d      <= bus.req_d[w_idx*DP_W +: DP_W];
                    r_dp_e      <= bus.req_e[w_idx*DP_W +: DP_W];
                    r_dp_opcode <= bus.req_opcode[w_idx*OPC_W +: OPC_W];
                    r_dp_sel_1  <= bus.req_sel_1[w_idx];
                    r_dp_sel_2  <= bus.req_sel_2[w_idx*SEL2_W +: SEL2_W];
                    r_cur_id    <= w_idx;
                    r_state     <= EXEC;
                end
                EXEC: begin
                    r_resp_data  <= bus.dp_out;
                    r_resp_carry <= bus.dp_carry_out;
                    r_resp_id    <= r_cur_id;
                    r_resp_valid <= 1'b1;
                    r_state      <= RESP;
                end
                RESP: if (bus.resp_ready) begin
                    r_resp_valid <= 1'b0;
                    r_rr_ptr     <= (r_cur_id == IDW'(NREQ-1)) ? '0 : r_cur_id + 1'b1;
                    r_state      <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.dp_a       = r_dp_a;
    assign bus.dp_b       = r_dp_b;
    assign bus.dp_c       = r_dp_c;
    assign bus.dp_d       = r_dp_d;
    assign bus.dp_e       = r_dp_e;
    assign bus.dp_opcode  = r_dp_opcode;
    assign bus.dp_sel_1   = r_dp_sel_1;
    assign bus.dp_sel_2   = r_dp_sel_2;
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_id    = r_resp_id;
    assign bus.resp_data  = r_resp_data;
    assign bus.resp_carry = r_resp_carry;

`ifdef DP_ARB_STATS_EN
    logic [STAT_W-1:0] r_cnt [NREQ];

    // Clear wins over a same-cycle grant; counts saturate rather than wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREQ; i++) r_cnt[i] <= '0;
        end else if (stats_clr) begin
            for (int i = 0; i < NREQ; i++) r_cnt[i] <= '0;
        end else if (w_accept && r_cnt[w_idx] != '1) begin
            r_cnt[w_idx] <= r_cnt[w_idx] + 1'b1;
        end
    end

    always_comb begin
        grant_count = '0;
        for (int i = 0; i < NREQ; i++) grant_count[i*STAT_W +: STAT_W] = r_cnt[i];
    end
`endif
endmodule

// File: tb/tb_dp_arbiter.sv
// Directed bench for dp_arbiter with a datapath model and a response scoreboard.
module tb_dp_arbiter;
    import dp_arb_pkg::*;

    localparam int NREQ = 4;
    localparam int W    = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    dp_arbiter_if #(.NREQ(NREQ), .DP_W(W)) bus ();

`ifdef DP_ARB_STATS_EN
    logic                 stats_clr = 1'b0;
    logic [NREQ*8-1:0]    grant_count;
`endif

    dp_arbiter #(.NREQ(NREQ), .DP_W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef DP_ARB_STATS_EN
        , .stats_clr   (stats_clr)
        , .grant_count (grant_count)
`endif
    );

    logic [2:0]      fa [NREQ], fb [NREQ], fc [NREQ], fd [NREQ], fe [NREQ], fop [NREQ];
    logic            fs1 [NREQ];
    logic [1:0]      fs2 [NREQ];
    logic [NREQ-1:0] vld  = '0;
    logic            rrdy = 1'b1;

    always_comb begin
        bus.req_a = '0; bus.req_b = '0; bus.req_c = '0; bus.req_d = '0; bus.req_e = '0;
        bus.req_opcode = '0; bus.req_sel_1 = '0; bus.req_sel_2 = '0;
        for (int i = 0; i < NREQ; i++) begin
            bus.req_a[i*W +: W]      = fa[i];
            bus.req_b[i*W +: W]      = fb[i];
            bus.req_c[i*W +: W]      = fc[i];
            bus.req_d[i*W +: W]      = fd[i];
            bus.req_e[i*W +: W]      = fe[i];
            bus.req_opcode[i*3 +: 3] = fop[i];
            bus.req_sel_1[i]         = fs1[i];
            bus.req_sel_2[i*2 +: 2]  = fs2[i];
        end
    end
    assign bus.req_valid  = vld;
    assign bus.resp_ready = rrdy;

    // Stand-in datapath; every field influences the result so mis-latched operands show up.
    function automatic logic [3:0] dp_model(input logic [2:0] a, b, c, d, e, op,
                                            input logic s1, input logic [1:0] s2);
        logic [3:0] t;
        t = {1'b0, a} + {1'b0, b};
        if (op == 3'b010) return {t[3], a | b};
        return {t[3] ^ op[0], t[2:0] ^ (s1 ? e : c) ^ (s2 == 2'd0 ? d : {1'b0, s2}) ^ op};
    endfunction

    assign {bus.dp_carry_out, bus.dp_out} = dp_model(bus.dp_a, bus.dp_b, bus.dp_c, bus.dp_d,
                                                     bus.dp_e, bus.dp_opcode, bus.dp_sel_1,
                                                     bus.dp_sel_2);

    typedef struct packed {
        logic [1:0] id;
        logic [2:0] data;
        logic       carry;
    } exp_t;
    exp_t sb [$];

    int checks   = 0;
    int failures = 0;
    int g_cyc    = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [2:0] a, b, c, d, e, op,
                           input logic s1, input logic [1:0] s2);
        fa[i] = a; fb[i] = b; fc[i] = c; fd[i] = d; fe[i] = e; fop[i] = op;
        fs1[i] = s1; fs2[i] = s2;
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic wait_grant(output int gid, input int budget);
        exp_t e;
        gid = -1;
        for (int n = 0; n < budget && gid < 0; n++) begin
            #1;
            if (bus.req_ready != '0) begin
                chk("ready_onehot", 32'($onehot(bus.req_ready)), 1);
                for (int i = 0; i < NREQ; i++) if (bus.req_ready[i]) gid = i;
                e.id = 2'(gid);
                {e.carry, e.data} = dp_model(fa[gid], fb[gid], fc[gid], fd[gid], fe[gid],
                                             fop[gid], fs1[gid], fs2[gid]);
                sb.push_back(e);
            end
            @(posedge clk);
            #1;
            if (gid >= 0) g_cyc = cyc;
        end
        chk("grant_timeout", 32'(gid >= 0), 1);
    endtask

    task automatic wait_resp(input int budget);
        exp_t e;
        bit seen = 1'b0;
        for (int n = 0; n < budget && !seen; n++) begin
            if (bus.resp_valid === 1'b1) begin
                seen = 1'b1;
                chk("resp_expected", 32'(sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("resp_id", 32'(bus.resp_id), 32'(e.id));
                    chk("resp_data", 32'(bus.resp_data), 32'(e.data));
                    chk("resp_carry", 32'(bus.resp_carry), 32'(e.carry));
                end
            end
            @(posedge clk);
            #1;
        end
        chk("resp_timeout", 32'(seen), 1);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_dp"}, 32'({bus.dp_a, bus.dp_b, bus.dp_c, bus.dp_d, bus.dp_e,
                               bus.dp_opcode, bus.dp_sel_1, bus.dp_sel_2}), 0);
        chk({tag, "_resp"}, 32'({bus.resp_valid, bus.resp_id, bus.resp_data, bus.resp_carry}), 0);
        chk({tag, "_ready"}, 32'(bus.req_ready), 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        sb.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int g;
        for (int i = 0; i < NREQ; i++) set_req(i, 0, 0, 0, 0, 0, 0, 1'b0, 2'd0);

        // Reset values.
        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset");
        rst_n = 1'b1;
        #1;
        chk("idle_no_ready", 32'(bus.req_ready), 0);

        // Reset mid-EXEC discards the op.
        set_req(1, 3'd5, 3'd2, 3'd1, 3'd6, 3'd4, 3'b001, 1'b1, 2'd2);
        vld = 4'b0010;
        wait_grant(g, 4);
        chk("rst_exec_gid", 32'(g), 1);
        chk("rst_exec_dp_a", 32'(bus.dp_a), 5);
        rst_n = 1'b0;
        vld   = '0;
        sb.delete();
        #2;
        chk_zero("rst_async");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("rst_rr_ptr", 32'(dut.r_rr_ptr), 0);
        for (int n = 0; n < 3; n++) begin
            chk("rst_no_resp", 32'(bus.resp_valid), 0);
            @(posedge clk);
            #1;
        end

        // Single requester 2: latency and captured result.
        set_req(2, 3'd3, 3'd5, 3'd0, 3'd0, 3'd0, 3'b010, 1'b0, 2'b01);
        vld = 4'b0100;
        #1;
        chk("r2_ready", 32'(bus.req_ready), 32'b0100);
        wait_grant(g, 1);
        chk("r2_gid", 32'(g), 2);
        vld = '0;
        chk("r2_ready_drop", 32'(bus.req_ready), 0);
        chk("r2_dp_a", 32'(bus.dp_a), 3);
        chk("r2_dp_b", 32'(bus.dp_b), 5);
        chk("r2_dp_opc", 32'(bus.dp_opcode), 32'b010);
        chk("r2_dp_sel2", 32'(bus.dp_sel_2), 32'b01);
        chk("r2_exec_noresp", 32'(bus.resp_valid), 0);
        @(posedge clk);
        #1;
        chk("r2_resp_valid", 32'(bus.resp_valid), 1);
        chk("r2_resp_id", 32'(bus.resp_id), 2);
        chk("r2_resp_data", 32'(bus.resp_data), 32'b111);
        chk("r2_resp_carry", 32'(bus.resp_carry), 1);
        wait_resp(1);
        chk("r2_resp_done", 32'(bus.resp_valid), 0);

        // Pointer now 3: req 3 then req 0.
        set_req(0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'b100, 1'b0, 2'd0);
        set_req(3, 3'd7, 3'd7, 3'd2, 3'd1, 3'd6, 3'b011, 1'b1, 2'd3);
        vld = 4'b1001;
        wait_grant(g, 2);
        chk("wrap_first", 32'(g), 3);
        vld[3] = 1'b0;
        wait_resp(4);
        wait_grant(g, 2);
        chk("wrap_second", 32'(g), 0);
        vld = '0;
        wait_resp(4);

        // Response stall with req 1 waiting.
        set_req(0, 3'd6, 3'd3, 3'd5, 3'd2, 3'd1, 3'b110, 1'b1, 2'd1);
        vld = 4'b0001;
        wait_grant(g, 2);
        chk("stall_gid0", 32'(g), 0);
        vld  = 4'b0010;
        rrdy = 1'b0;
        set_req(1, 3'd2, 3'd6, 3'd7, 3'd3, 3'd0, 3'b000, 1'b0, 2'd0);
        @(posedge clk);
        #1;
        for (int n = 0; n < 10; n++) begin
            chk("stall_valid", 32'(bus.resp_valid), 1);
            chk("stall_id", 32'(bus.resp_id), 32'(sb[0].id));
            chk("stall_data", 32'({bus.resp_data, bus.resp_carry}), 32'({sb[0].data, sb[0].carry}));
            chk("stall_ready", 32'(bus.req_ready), 0);
            @(posedge clk);
            #1;
        end
        rrdy = 1'b1;
        wait_resp(1);
        wait_grant(g, 1);
        chk("stall_then_r1", 32'(g), 1);
        vld = '0;
        wait_resp(4);

        // All four continuously valid: 0,1,2,3,0 every 3 cycles.
        do_reset();
        set_req(0, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'b111, 1'b0, 2'd0);
        set_req(1, 3'd2, 3'd4, 3'd6, 3'd0, 3'd2, 3'b101, 1'b1, 2'd3);
        set_req(2, 3'd7, 3'd1, 3'd3, 3'd5, 3'd7, 3'b010, 1'b0, 2'd2);
        set_req(3, 3'd4, 3'd4, 3'd0, 3'd7, 3'd3, 3'b001, 1'b1, 2'd1);
        vld = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            int prev;
            prev = g_cyc;
            wait_grant(g, 6);
            chk("rr_order", 32'(g), 32'(i % NREQ));
            if (i > 0) chk("rr_spacing", 32'(g_cyc - prev), 3);
            wait_resp(3);
        end
        vld = '0;

`ifdef DP_ARB_STATS_EN
        do_reset();
        chk("stats_reset", 32'(grant_count), 0);
        vld = 4'b0001;
        for (int i = 0; i < 300; i++) begin
            wait_grant(g, 2);
            wait_resp(3);
        end
        chk("stats_sat", 32'(grant_count[7:0]), 255);
        chk("stats_other", 32'(grant_count[31:8]), 0);
        stats_clr = 1'b1;
        wait_grant(g, 1);
        stats_clr = 1'b0;
        chk("stats_clr", 32'(grant_count[7:0]), 0);
        vld = '0;
        wait_resp(3);
`endif

        chk("sb_drained", 32'(sb.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
